// File: rtl/shift_register_pkg.sv
// Shared opcodes, FSM state encodings and shift_step modes for the shift register unit.
package shift_register_pkg;

  localparam logic [2:0] HOLD   = 3'b000;
  localparam logic [2:0] LOAD   = 3'b001;
  localparam logic [2:0] SHIFTR = 3'b010;
  localparam logic [2:0] SHIFTL = 3'b011;
  localparam logic [2:0] CLEAR  = 3'b100;
  localparam logic [2:0] ROTR   = 3'b101;
  localparam logic [2:0] ROTL   = 3'b110;
  localparam logic [2:0] MSHIFT = 3'b111;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] SHIFTING = 1'b1;

  // Bit 1 selects rotate, bit 0 selects left.
  localparam logic [1:0] MODE_SHR = 2'b00;
  localparam logic [1:0] MODE_SHL = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate step; shared by single-cycle opcodes and MSHIFT steps.
module shift_step
  import shift_register_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  input  logic [1:0]       mode,
  input  logic             fill,
  output logic [WIDTH-1:0] next_value,
  output logic             ejected
);

  always_comb begin
    next_value = value;
    ejected    = 1'b0;
    case (mode)
      MODE_SHR: begin
        next_value = {fill, value[WIDTH-1:1]};
        ejected    = value[0];
      end
      MODE_SHL: begin
        next_value = {value[WIDTH-2:0], fill};
        ejected    = value[WIDTH-1];
      end
      MODE_ROR: begin
        next_value = {value[0], value[WIDTH-1:1]};
        ejected    = value[0];
      end
      MODE_ROL: begin
        next_value = {value[WIDTH-2:0], value[WIDTH-1]};
        ejected    = value[WIDTH-1];
      end
      default: begin
        next_value = value;
        ejected    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_register_unit.sv
// Operand/accumulator register: hold/load/shift/rotate/clear plus a multi-cycle
// shift-by-N (MSHIFT) with busy/done handshake. busy is a direct decode of the FSM state.
module shift_register_unit
  import shift_register_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int SHAMT_W = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [2:0]         instruction,
  input  logic [WIDTH-1:0]   inX,
  input  logic               serial_in,
  input  logic               dir,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   outX,
  output logic               serial_out,
  output logic               busy,
  output logic               done
);

  localparam logic [SHAMT_W-1:0] COUNT_ONE = SHAMT_W'(1);

  logic [WIDTH-1:0]   data_q;
  logic               serial_q;
  logic               done_q;
  logic [0:0]         state_q;
  logic [SHAMT_W-1:0] count_q;
  logic               dir_q;
  logic               fill_q;

  logic [1:0]         step_mode;
  logic               step_fill;
  logic [WIDTH-1:0]   step_value;
  logic               step_ejected;

  // While shifting, the step follows the latched direction/fill, not the live inputs.
  always_comb begin
    step_mode = MODE_SHR;
    step_fill = serial_in;
    if (state_q == SHIFTING) begin
      step_mode = dir_q ? MODE_SHL : MODE_SHR;
      step_fill = fill_q;
    end else begin
      case (instruction)
        SHIFTR:  step_mode = MODE_SHR;
        SHIFTL:  step_mode = MODE_SHL;
        ROTR:    step_mode = MODE_ROR;
        ROTL:    step_mode = MODE_ROL;
        default: step_mode = MODE_SHR;
      endcase
    end
  end

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value      (data_q),
    .mode       (step_mode),
    .fill       (step_fill),
    .next_value (step_value),
    .ejected    (step_ejected)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_q   <= '0;
      serial_q <= 1'b0;
      done_q   <= 1'b0;
      state_q  <= IDLE;
      count_q  <= '0;
      dir_q    <= 1'b0;
      fill_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          case (instruction)
            LOAD: data_q <= inX;
            SHIFTR, SHIFTL, ROTR, ROTL: begin
              data_q   <= step_value;
              serial_q <= step_ejected;
            end
            CLEAR: data_q <= '0;
            MSHIFT: begin
              if (shamt == '0) begin
                done_q <= 1'b1;
              end else begin
                count_q <= shamt;
                dir_q   <= dir;
                fill_q  <= serial_in;
                state_q <= SHIFTING;
              end
            end
            default: ;
          endcase
        end
        SHIFTING: begin
          if (instruction == CLEAR) begin
            data_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
          end else begin
            data_q   <= step_value;
            serial_q <= step_ejected;
            count_q  <= count_q - COUNT_ONE;
            // Last step: done rises at the same edge busy falls.
            if (count_q == COUNT_ONE) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign outX       = data_q;
  assign serial_out = serial_q;
  assign busy       = (state_q == SHIFTING);
  assign done       = done_q;

endmodule
